// File: rtl/goe_port_dispatch_if.sv
// goe_port_dispatch_if: ingress packet stream and the two egress port bundles of the gate-output engine
interface goe_port_dispatch_if;
    logic [133:0] in_goe_data;
    logic         in_goe_data_wr;
    logic         in_goe_valid;
    logic         in_goe_valid_wr;
    logic         in_goe_ready;
    logic [133:0] out_port0_data;
    logic         out_port0_data_wr;
    logic         out_port0_valid;
    logic         out_port0_valid_wr;
    logic         port0_ready;
    logic [133:0] out_port1_data;
    logic         out_port1_data_wr;
    logic         out_port1_valid;
    logic         out_port1_valid_wr;
    logic         port1_ready;

    modport master (
        output in_goe_data, in_goe_data_wr, in_goe_valid, in_goe_valid_wr, port0_ready, port1_ready,
        input  in_goe_ready, out_port0_data, out_port0_data_wr, out_port0_valid, out_port0_valid_wr,
               out_port1_data, out_port1_data_wr, out_port1_valid, out_port1_valid_wr
    );

    modport slave (
        input  in_goe_data, in_goe_data_wr, in_goe_valid, in_goe_valid_wr, port0_ready, port1_ready,
        output in_goe_ready, out_port0_data, out_port0_data_wr, out_port0_valid, out_port0_valid_wr,
               out_port1_data, out_port1_data_wr, out_port1_valid, out_port1_valid_wr
    );
endinterface

// File: rtl/goe_port_dispatch.sv
// goe_port_dispatch: buffers whole packets, then drops them or forwards them to port0/port1 on the tail verdict
module goe_port_dispatch #(
    parameter int DEPTH_LOG2    = 8,
    parameter int ALF_TH        = 200,
    parameter int MD_DEPTH_LOG2 = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    goe_port_dispatch_if.slave bus,
    output logic [63:0]        goe_pktin_cnt,
    output logic [63:0]        goe_port0out_cnt,
    output logic [63:0]        goe_port1out_cnt,
    output logic [63:0]        goe_discard_cnt
);
    typedef enum logic [1:0] {IDLE, SEND0, SEND1, DROP} state_t;

    localparam logic [DEPTH_LOG2:0] ALF = (DEPTH_LOG2+1)'(ALF_TH);

    state_t                   state, state_nx;
    logic [133:0]             mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0]    wp, rp;
    logic [DEPTH_LOG2:0]      dcnt;
    logic [2:0]               vmem [2**MD_DEPTH_LOG2];
    logic [MD_DEPTH_LOG2-1:0] vwp, vrp;
    logic [MD_DEPTH_LOG2:0]   vcnt;
    logic [1:0]               outport;
    logic [133:0]             rdata;
    logic [2:0]               vhead;
    logic                     rd, vpop, tail, s0, s1;

    assign rdata = mem[rp];
    assign vhead = vmem[vrp];
    assign tail  = rd && rdata[133:132] == 2'b10;
    assign s0    = rd && state == SEND0;
    assign s1    = rd && state == SEND1;

    // verdict entry is {valid, outport}; outport comes from the head beat seen earlier
    always_ff @(posedge clk) begin
        if (bus.in_goe_data_wr) mem[wp] <= bus.in_goe_data;
        if (bus.in_goe_valid_wr) vmem[vwp] <= {bus.in_goe_valid, outport};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp               <= '0;
            rp               <= '0;
            dcnt             <= '0;
            vwp              <= '0;
            vrp              <= '0;
            vcnt             <= '0;
            outport          <= '0;
            state            <= IDLE;
            bus.in_goe_ready <= 1'b0;
        end else begin
            wp               <= wp + DEPTH_LOG2'(bus.in_goe_data_wr);
            rp               <= rp + DEPTH_LOG2'(rd);
            dcnt             <= dcnt + (DEPTH_LOG2+1)'(bus.in_goe_data_wr) - (DEPTH_LOG2+1)'(rd);
            vwp              <= vwp + MD_DEPTH_LOG2'(bus.in_goe_valid_wr);
            vrp              <= vrp + MD_DEPTH_LOG2'(vpop);
            vcnt             <= vcnt + (MD_DEPTH_LOG2+1)'(bus.in_goe_valid_wr) - (MD_DEPTH_LOG2+1)'(vpop);
            if (bus.in_goe_data_wr && bus.in_goe_data[133:132] == 2'b01) outport <= bus.in_goe_data[127:126];
            state            <= state_nx;
            bus.in_goe_ready <= dcnt < ALF && !vcnt[MD_DEPTH_LOG2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_port0_data     <= '0;
            bus.out_port0_data_wr  <= 1'b0;
            bus.out_port0_valid    <= 1'b0;
            bus.out_port0_valid_wr <= 1'b0;
            bus.out_port1_data     <= '0;
            bus.out_port1_data_wr  <= 1'b0;
            bus.out_port1_valid    <= 1'b0;
            bus.out_port1_valid_wr <= 1'b0;
            goe_pktin_cnt          <= '0;
            goe_port0out_cnt       <= '0;
            goe_port1out_cnt       <= '0;
            goe_discard_cnt        <= '0;
        end else begin
            if (s0) bus.out_port0_data <= rdata;
            if (s1) bus.out_port1_data <= rdata;
            bus.out_port0_data_wr  <= s0;
            bus.out_port0_valid    <= s0 && tail;
            bus.out_port0_valid_wr <= s0 && tail;
            bus.out_port1_data_wr  <= s1;
            bus.out_port1_valid    <= s1 && tail;
            bus.out_port1_valid_wr <= s1 && tail;
            goe_pktin_cnt          <= goe_pktin_cnt + 64'(bus.in_goe_valid_wr);
            goe_port0out_cnt       <= goe_port0out_cnt + 64'(s0 && tail);
            goe_port1out_cnt       <= goe_port1out_cnt + 64'(s1 && tail);
            goe_discard_cnt        <= goe_discard_cnt + 64'(tail && state == DROP);
        end
    end

    // head-of-line: a verdict for a busy port holds back everything behind it
    always_comb begin
        state_nx = state;
        vpop     = 1'b0;
        rd       = 1'b0;
        case (state)
            IDLE: begin
                if (vcnt != '0) begin
                    if (!vhead[2] || vhead[1]) begin
                        vpop     = 1'b1;
                        state_nx = DROP;
                    end else if (!vhead[0] && bus.port0_ready) begin
                        vpop     = 1'b1;
                        state_nx = SEND0;
                    end else if (vhead[0] && bus.port1_ready) begin
                        vpop     = 1'b1;
                        state_nx = SEND1;
                    end
                end
            end
            default: begin
                rd = 1'b1;
                if (rdata[133:132] == 2'b10) state_nx = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_goe_port_dispatch.sv
// tb_goe_port_dispatch: directed scenarios for the gate-output dispatch engine
module tb_goe_port_dispatch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] pktin_cnt, p0_cnt, p1_cnt, disc_cnt;
    logic [63:0] e_in = '0, e_p0 = '0, e_p1 = '0, e_disc = '0;
    int          cyc = 0, passed = 0, total = 0, bad = 0, vw_cyc = 0;
    logic [133:0] p0_q[$], p1_q[$], x0_q[$], x1_q[$];
    int          p0_c[$], p1_c[$];

    goe_port_dispatch_if bus();

    goe_port_dispatch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .goe_pktin_cnt   (pktin_cnt),
        .goe_port0out_cnt(p0_cnt),
        .goe_port1out_cnt(p1_cnt),
        .goe_discard_cnt (disc_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // egress monitor: records beats and flags verdict strobes that are not exactly on a tail
    always @(negedge clk) begin
        if (bus.out_port0_data_wr) begin p0_q.push_back(bus.out_port0_data); p0_c.push_back(cyc); end
        if (bus.out_port1_data_wr) begin p1_q.push_back(bus.out_port1_data); p1_c.push_back(cyc); end
        if (bus.out_port0_valid_wr !== (bus.out_port0_data_wr && bus.out_port0_data[133:132] == 2'b10) ||
            (bus.out_port0_valid_wr && !bus.out_port0_valid)) bad = bad + 1;
        if (bus.out_port1_valid_wr !== (bus.out_port1_data_wr && bus.out_port1_data[133:132] == 2'b10) ||
            (bus.out_port1_valid_wr && !bus.out_port1_valid)) bad = bad + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [133:0] mk_beat(input int k, input int n, input logic [1:0] port, input logic [15:0] tag);
        logic [1:0] t = (k == 0) ? 2'b01 : (k == n - 1) ? 2'b10 : 2'b11;
        return {t, 4'(k), port, 86'h0, tag, 8'(k), 16'hC3A5};
    endfunction

    task automatic drive_beat(input int k, input int n, input logic [1:0] port, input logic v, input logic [15:0] tag);
        bus.in_goe_data     = mk_beat(k, n, port, tag);
        bus.in_goe_data_wr  = 1'b1;
        bus.in_goe_valid_wr = (k == n - 1);
        bus.in_goe_valid    = (k == n - 1) && v;
        if (v && port == 2'd0) x0_q.push_back(bus.in_goe_data);
        if (v && port == 2'd1) x1_q.push_back(bus.in_goe_data);
        if (k == n - 1) begin
            vw_cyc = cyc;
            e_in = e_in + 64'd1;
            if (v && port == 2'd0) e_p0 = e_p0 + 64'd1;
            else if (v && port == 2'd1) e_p1 = e_p1 + 64'd1;
            else e_disc = e_disc + 64'd1;
        end
    endtask

    task automatic send_pkt(input int n, input logic [1:0] port, input logic v, input logic [15:0] tag);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            drive_beat(k, n, port, v, tag);
        end
    endtask

    task automatic bus_zero();
        bus.in_goe_data     = '0;
        bus.in_goe_data_wr  = 1'b0;
        bus.in_goe_valid    = 1'b0;
        bus.in_goe_valid_wr = 1'b0;
    endtask

    task automatic bus_idle();
        @(negedge clk);
        bus_zero();
    endtask

    task automatic clear_q();
        p0_q.delete(); p1_q.delete(); x0_q.delete(); x1_q.delete(); p0_c.delete(); p1_c.delete();
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (p0_q.size() == x0_q.size() && p1_q.size() == x1_q.size() &&
                disc_cnt == e_disc && p0_cnt == e_p0 && p1_cnt == e_p1) ok = 1'b1;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        bus_zero();
        bus.port0_ready = 1'b0;
        bus.port1_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.in_goe_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", bus.in_goe_ready); else passed++;
        total++; if ({bus.out_port0_data_wr, bus.out_port1_data_wr, bus.out_port0_valid_wr, bus.out_port1_valid_wr} !== 4'b0)
            $display("FAIL rst_strobes got %b want 0000", {bus.out_port0_data_wr, bus.out_port1_data_wr, bus.out_port0_valid_wr, bus.out_port1_valid_wr});
        else passed++;
        total++; if ((pktin_cnt | p0_cnt | p1_cnt | disc_cnt) !== 64'd0) $display("FAIL rst_counters got nonzero want 0"); else passed++;
        rst_n = 1'b1;
        #1;
        total++; if (bus.in_goe_ready !== 1'b0) $display("FAIL rst_release_ready got %b want 0", bus.in_goe_ready); else passed++;
        @(negedge clk);
        total++; if (bus.in_goe_ready !== 1'b1) $display("FAIL ready_after_release got %b want 1", bus.in_goe_ready); else passed++;
    endtask

    task automatic test_port0();
        bit ok;
        bus.port0_ready = 1'b1;
        bus.port1_ready = 1'b1;
        send_pkt(4, 2'd0, 1'b1, 16'h1111);
        bus_idle();
        wait_drain(ok);
        total++; if (!ok) $display("FAIL p0_drain timed out got 0 want 1"); else passed++;
        total++; if (p0_q.size() !== 4) $display("FAIL p0_beats got %0d want 4", p0_q.size()); else passed++;
        total++; if (p1_q.size() !== 0) $display("FAIL p0_no_p1 got %0d want 0", p1_q.size()); else passed++;
        for (int i = 0; i < p0_q.size() && i < x0_q.size(); i++) begin
            total++; if (p0_q[i] !== x0_q[i]) $display("FAIL p0_beat[%0d] got %h want %h", i, p0_q[i], x0_q[i]); else passed++;
        end
        if (p0_c.size() == 4) begin
            total++; if (p0_c[0] !== vw_cyc + 3) $display("FAIL p0_latency got %0d want %0d", p0_c[0] - vw_cyc, 3); else passed++;
            total++; if (p0_c[3] !== vw_cyc + 6) $display("FAIL p0_contiguous got %0d want %0d", p0_c[3] - vw_cyc, 6); else passed++;
        end
        total++; if (p0_cnt !== e_p0) $display("FAIL p0_cnt got %0d want %0d", p0_cnt, e_p0); else passed++;
        total++; if (pktin_cnt !== e_in) $display("FAIL p0_pktin got %0d want %0d", pktin_cnt, e_in); else passed++;
        total++; if (bad !== 0) $display("FAIL p0_strobes got %0d bad want 0", bad); else passed++;
        clear_q();
    endtask

    task automatic test_port1();
        bit ok;
        send_pkt(4, 2'd1, 1'b1, 16'h1111);
        bus_idle();
        wait_drain(ok);
        total++; if (!ok) $display("FAIL p1_drain timed out got 0 want 1"); else passed++;
        total++; if (p1_q.size() !== 4) $display("FAIL p1_beats got %0d want 4", p1_q.size()); else passed++;
        total++; if (p0_q.size() !== 0) $display("FAIL p1_no_p0 got %0d want 0", p0_q.size()); else passed++;
        for (int i = 0; i < p1_q.size() && i < x1_q.size(); i++) begin
            total++; if (p1_q[i] !== x1_q[i]) $display("FAIL p1_beat[%0d] got %h want %h", i, p1_q[i], x1_q[i]); else passed++;
        end
        if (p1_c.size() == 4) begin
            total++; if (p1_c[0] !== vw_cyc + 3) $display("FAIL p1_latency got %0d want %0d", p1_c[0] - vw_cyc, 3); else passed++;
        end
        total++; if (p1_cnt !== e_p1) $display("FAIL p1_cnt got %0d want %0d", p1_cnt, e_p1); else passed++;
        total++; if (p0_cnt !== e_p0) $display("FAIL p1_p0cnt got %0d want %0d", p0_cnt, e_p0); else passed++;
        total++; if (bad !== 0) $display("FAIL p1_strobes got %0d bad want 0", bad); else passed++;
        clear_q();
    endtask

    task automatic test_drop();
        bit ok;
        send_pkt(4, 2'd0, 1'b0, 16'h2222);
        bus_idle();
        send_pkt(3, 2'd3, 1'b1, 16'h3333);
        bus_idle();
        wait_drain(ok);
        total++; if (!ok) $display("FAIL drop_drain timed out got 0 want 1"); else passed++;
        total++; if (p0_q.size() + p1_q.size() !== 0) $display("FAIL drop_egress got %0d beats want 0", p0_q.size() + p1_q.size()); else passed++;
        total++; if (disc_cnt !== e_disc) $display("FAIL drop_cnt got %0d want %0d", disc_cnt, e_disc); else passed++;
        total++; if (pktin_cnt !== e_in) $display("FAIL drop_pktin got %0d want %0d", pktin_cnt, e_in); else passed++;
        clear_q();
    endtask

    task automatic test_hol();
        bit ok;
        bus.port0_ready = 1'b0;
        bus.port1_ready = 1'b1;
        send_pkt(4, 2'd0, 1'b1, 16'hAAAA);
        bus_idle();
        send_pkt(3, 2'd1, 1'b1, 16'hBBBB);
        bus_idle();
        repeat (20) @(negedge clk);
        total++; if (p0_q.size() !== 0) $display("FAIL hol_p0_blocked got %0d want 0", p0_q.size()); else passed++;
        total++; if (p1_q.size() !== 0) $display("FAIL hol_p1_blocked got %0d want 0", p1_q.size()); else passed++;
        bus.port0_ready = 1'b1;
        wait_drain(ok);
        total++; if (!ok) $display("FAIL hol_drain timed out got 0 want 1"); else passed++;
        for (int i = 0; i < p0_q.size() && i < x0_q.size(); i++) begin
            total++; if (p0_q[i] !== x0_q[i]) $display("FAIL hol_a[%0d] got %h want %h", i, p0_q[i], x0_q[i]); else passed++;
        end
        for (int i = 0; i < p1_q.size() && i < x1_q.size(); i++) begin
            total++; if (p1_q[i] !== x1_q[i]) $display("FAIL hol_b[%0d] got %h want %h", i, p1_q[i], x1_q[i]); else passed++;
        end
        if (p0_c.size() == 4 && p1_c.size() == 3) begin
            total++; if (!(p1_c[0] > p0_c[3])) $display("FAIL hol_order got b_first=%0d want > a_last=%0d", p1_c[0], p0_c[3]); else passed++;
        end
        total++; if (bad !== 0) $display("FAIL hol_strobes got %0d bad want 0", bad); else passed++;
        clear_q();
    endtask

    task automatic test_flow();
        bit ok;
        int b = 0;
        bus.port0_ready = 1'b0;
        bus.port1_ready = 1'b0;
        for (int g = 0; g < 250; g++) begin
            @(negedge clk);
            if (b >= 196) begin
                total++;
                if (bus.in_goe_ready !== (b <= 200)) $display("FAIL flow_ready@%0d got %b want %b", b, bus.in_goe_ready, b <= 200);
                else passed++;
            end
            if (b % 16 == 0 && !bus.in_goe_ready) break;
            drive_beat(b % 16, 16, 2'((b / 16) % 2), 1'b1, 16'(16'h4000 + b / 16));
            b++;
        end
        bus_zero();
        total++; if (b !== 208) $display("FAIL flow_accepted got %0d beats want 208", b); else passed++;
        total++; if (p0_q.size() + p1_q.size() !== 0) $display("FAIL flow_blocked got %0d beats want 0", p0_q.size() + p1_q.size()); else passed++;
        bus.port0_ready = 1'b1;
        bus.port1_ready = 1'b1;
        wait_drain(ok);
        total++; if (!ok) $display("FAIL flow_drain timed out got 0 want 1"); else passed++;
        for (int i = 0; i < p0_q.size() && i < x0_q.size(); i++) begin
            total++; if (p0_q[i] !== x0_q[i]) $display("FAIL flow_p0[%0d] got %h want %h", i, p0_q[i], x0_q[i]); else passed++;
        end
        for (int i = 0; i < p1_q.size() && i < x1_q.size(); i++) begin
            total++; if (p1_q[i] !== x1_q[i]) $display("FAIL flow_p1[%0d] got %h want %h", i, p1_q[i], x1_q[i]); else passed++;
        end
        total++; if (bus.in_goe_ready !== 1'b1) $display("FAIL flow_ready_back got %b want 1", bus.in_goe_ready); else passed++;
        total++; if (bad !== 0) $display("FAIL flow_strobes got %0d bad want 0", bad); else passed++;
        clear_q();
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen = 1'b0;
        send_pkt(8, 2'd0, 1'b1, 16'h5555);
        bus_idle();
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (p0_q.size() >= 2) seen = 1'b1;
        end
        total++; if (!seen) $display("FAIL mid_start timed out got 0 want 1"); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if ({bus.out_port0_data_wr, bus.out_port0_valid_wr} !== 2'b00)
            $display("FAIL mid_strobes got %b want 00", {bus.out_port0_data_wr, bus.out_port0_valid_wr});
        else passed++;
        total++; if ((pktin_cnt | p0_cnt | p1_cnt | disc_cnt) !== 64'd0) $display("FAIL mid_counters got nonzero want 0"); else passed++;
        total++; if (bus.in_goe_ready !== 1'b0) $display("FAIL mid_ready got %b want 0", bus.in_goe_ready); else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        e_in = '0; e_p0 = '0; e_p1 = '0; e_disc = '0;
        clear_q();
        @(negedge clk);
        send_pkt(4, 2'd0, 1'b1, 16'h6666);
        bus_idle();
        wait_drain(ok);
        total++; if (!ok) $display("FAIL mid_drain timed out got 0 want 1"); else passed++;
        total++; if (p0_q.size() !== 4) $display("FAIL mid_beats got %0d want 4", p0_q.size()); else passed++;
        for (int i = 0; i < p0_q.size() && i < x0_q.size(); i++) begin
            total++; if (p0_q[i] !== x0_q[i]) $display("FAIL mid_beat[%0d] got %h want %h", i, p0_q[i], x0_q[i]); else passed++;
        end
        total++; if (p0_cnt !== 64'd1) $display("FAIL mid_p0cnt got %0d want 1", p0_cnt); else passed++;
        total++; if (pktin_cnt !== 64'd1) $display("FAIL mid_pktin got %0d want 1", pktin_cnt); else passed++;
        clear_q();
    endtask

    initial begin
        test_reset();
        test_port0();
        test_port1();
        test_drop();
        test_hol();
        test_flow();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/goe_port_dispatch.md
Name: goe_port_dispatch

Overview:
- Gate-output engine directly downstream of the UM packet-out stream (ebm output), upstream of the two physical port TX interfaces.
- Buffers whole packets, then drops them on the end-of-packet valid verdict or the outport field, or forwards them to port0 or port1.
- Exposes pktin/port0out/port1out/discard counters to the lcm register block.

Parameters:
- DEPTH_LOG2, 8, data FIFO depth = 2^DEPTH_LOG2 beats of 134 bits
- ALF_TH, 200, data FIFO used-word threshold at or above which in_goe_ready deasserts
- MD_DEPTH_LOG2, 4, verdict FIFO depth = 2^MD_DEPTH_LOG2 entries

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_goe_data  in  134  packet beat; [133:132] 01=head, 11=body, 10=tail; [131:128] invalid-byte count; [127:0] data
- in_goe_data_wr  in  1  beat strobe
- in_goe_valid  in  1  packet verdict: 1 keep, 0 drop
- in_goe_valid_wr  in  1  verdict strobe, coincident with the tail beat
- in_goe_ready  out  1  upstream may start a new packet
- out_port0_data / out_port1_data  out  134  egress beats
- out_port0_data_wr / out_port1_data_wr  out  1  beat strobes
- out_port0_valid / out_port1_valid  out  1  verdict, always 1 when forwarded
- out_port0_valid_wr / out_port1_valid_wr  out  1  pulse with the tail beat
- port0_ready / port1_ready  in  1  port can accept one maximum-size packet
- goe_pktin_cnt  out  64  packets received (verdict strobes)
- goe_port0out_cnt / goe_port1out_cnt  out  64  packets fully sent per port
- goe_discard_cnt  out  64  packets dropped

Behaviour:
- Reset values: all outputs 0 except in_goe_ready; counters 0; FSM IDLE; both FIFOs empty. in_goe_ready resets to 0 and becomes 1 on the first cycle after reset release.
- Ingress:
  - Every in_goe_data_wr beat is written to the data FIFO.
  - On in_goe_valid_wr, push {in_goe_valid, outport} to the verdict FIFO. outport = data[127:126] latched from the head beat of the same packet.
  - goe_pktin_cnt increments on every in_goe_valid_wr.
- Flow control:
  - in_goe_ready = (data usedw < ALF_TH) AND verdict FIFO not full, registered with 1-cycle latency.
  - Upstream samples ready only at packet start. A packet already in progress is always accepted.
- FSM states IDLE, SEND0, SEND1, DROP:
  - IDLE, verdict FIFO non-empty: evaluate the head entry.
    - valid=0 or outport in {2,3}: pop the entry, go to DROP.
    - valid=1, outport=0, port0_ready=1: pop, go to SEND0.
    - valid=1, outport=1, port1_ready=1: pop, go to SEND1.
    - Target port not ready: stay in IDLE (head-of-line blocking, no reordering).
  - SEND0/SEND1:
    - Read one data beat per cycle; the beat appears on the port registered one cycle after the read.
    - On reading the tail beat (10), return to IDLE.
    - out_portX_valid_wr and out_portX_valid=1 are asserted in the same cycle as the tail out_portX_data_wr.
    - goe_portXout_cnt increments in that same cycle.
    - Port ready is not rechecked mid-packet.
  - DROP: read beats with no output strobes. On the tail, increment goe_discard_cnt and return to IDLE.
- Timing:
  - Minimum 1 idle cycle between packets leaving the FSM (IDLE re-evaluation).
  - Latency from verdict strobe to first egress beat is 3 cycles when the FIFO is otherwise empty and the port is ready.
- Data FIFO read and write occur in the same cycle without conflict. A read is never issued on an empty FIFO. The FSM only enters SEND or DROP once the full packet is stored, because the verdict arrives with the tail.
- Counters are 64-bit and wrap modulo 2^64.
- Reset mid-packet clears FIFOs, FSM, and strobes immediately. A partial packet on the egress is truncated, and the port is responsible for discarding it.
- Single-beat packets (head and tail in one beat, [133:132]=10 without 01) are not supported. Minimum packet length is 2 beats.

Test Plan:
- 4-beat packet, outport=0, valid=1, port0_ready=1 -> 4 beats on port0 starting 3 cycles after valid_wr; valid_wr on tail; port0out_cnt=1, pktin_cnt=1.
- Same packet with outport=1 -> identical beats on port1, none on port0; port1out_cnt=1.
- Packet with valid=0, then packet with outport=3 -> no egress strobes; discard_cnt=2, pktin_cnt=2.
- port0_ready=0, packet A to port0 then packet B to port1 -> neither is sent until port0_ready=1; then A is sent fully, then B; order preserved.
- Continuous 16-beat packets with both port readies held at 0 -> in_goe_ready falls within 1 cycle of usedw reaching 200; FIFO does not overflow; all packets emerge intact after readies are set to 1.
- Assert rst_n low mid-SEND0 for 2 cycles -> all strobes 0 and counters 0 immediately; a new packet after release forwards normally.
